// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    // EX operand source selects
    localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MW = 2'b01;
    localparam logic [FWD_W-1:0] FWD_EM = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    // Stall/flush enables driven into the PC and pipeline registers
    typedef struct packed {
        logic pc_stall;
        logic pc_branch_en;
        logic fd_stall;
        logic fd_flush;
        logic de_stall;
        logic de_flush;
        logic em_stall;
        logic mw_bubble;
    } hazard_ctrl_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding compare for one EX operand: picks EM over MW over regfile.
// Ports: rs (operand source reg), em_rd/em_reg_write, mw_rd/mw_reg_write,
//        fwd_sel_c (combinational select, FWD_* encoding).
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] em_rd,
    input  logic              em_reg_write,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic              mw_reg_write,
    output logic [FWD_W-1:0]  fwd_sel_c
);

    // x0 is hardwired zero, so a write to it never forwards
    always_comb begin
        fwd_sel_c = FWD_RF;
        if (em_reg_write && (em_rd != '0) && (em_rd == rs)) begin
            fwd_sel_c = FWD_EM;
        end else if (mw_reg_write && (mw_rd != '0) && (mw_rd == rs)) begin
            fwd_sel_c = FWD_MW;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32 pipeline.
// Inputs: decode/execute source regs and use bits, EX load/rd and branch
//   resolution, EM/MW rd + reg_write, dmem request/ready handshake.
// Outputs: PC/FD/DE/EM stall and flush enables, MW bubble, EX forwarding
//   selects (combinational), sticky dmem timeout flag and wrapping
//   stall-cycle / branch-flush performance counters (registered).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [REG_AW-1:0] d_rs1_i,
    input  logic [REG_AW-1:0] d_rs2_i,
    input  logic              d_uses_rs1_i,
    input  logic              d_uses_rs2_i,
    input  logic [REG_AW-1:0] de_rs1_i,
    input  logic [REG_AW-1:0] de_rs2_i,
    input  logic [REG_AW-1:0] de_rd_i,
    input  logic              de_mem_read_i,
    input  logic              e_pc_select_i,
    input  logic [REG_AW-1:0] em_rd_i,
    input  logic              em_reg_write_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    input  logic [REG_AW-1:0] mw_rd_i,
    input  logic              mw_reg_write_i,
    output logic              pc_stall_o,
    output logic              pc_branch_en_o,
    output logic              fd_stall_o,
    output logic              fd_flush_o,
    output logic              de_stall_o,
    output logic              de_flush_o,
    output logic              em_stall_o,
    output logic              mw_bubble_o,
    output logic [FWD_W-1:0]  fwd_a_o,
    output logic [FWD_W-1:0]  fwd_b_o,
    output logic              mem_timeout_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_count_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    hazard_ctrl_t      ctrl;
    logic              freeze;
    logic              branch_taken;
    logic              load_use;
    logic [FWD_W-1:0]  fwd_a_c, fwd_b_c;

    hazard_fwd_unit u_fwd_a (
        .rs           (de_rs1_i),
        .em_rd        (em_rd_i),
        .em_reg_write (em_reg_write_i),
        .mw_rd        (mw_rd_i),
        .mw_reg_write (mw_reg_write_i),
        .fwd_sel_c    (fwd_a_c)
    );

    hazard_fwd_unit u_fwd_b (
        .rs           (de_rs2_i),
        .em_rd        (em_rd_i),
        .em_reg_write (em_reg_write_i),
        .mw_rd        (mw_rd_i),
        .mw_reg_write (mw_reg_write_i),
        .fwd_sel_c    (fwd_b_c)
    );

    assign load_use = de_mem_read_i && (de_rd_i != '0) &&
                      ((d_uses_rs1_i && (de_rd_i == d_rs1_i)) ||
                       (d_uses_rs2_i && (de_rd_i == d_rs2_i)));

    // Next state and stall/flush decode; priority freeze > branch > load-use
    always_comb begin
        ctrl         = '0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        branch_taken = 1'b0;

        if (!reset_i) begin
            ctrl.fd_flush  = 1'b1;
            ctrl.de_flush  = 1'b1;
            ctrl.mw_bubble = 1'b1;
            state_nxt      = RUN;
            wait_cnt_nxt   = '0;
        end else begin
            unique case (state)
                RUN:      freeze = dmem_req_i && !dmem_ready_i;
                MEM_WAIT: freeze = !dmem_ready_i;
                default:  freeze = 1'b0;
            endcase

            if (freeze) begin
                ctrl.pc_stall  = 1'b1;
                ctrl.fd_stall  = 1'b1;
                ctrl.de_stall  = 1'b1;
                ctrl.em_stall  = 1'b1;
                ctrl.mw_bubble = 1'b1;
                state_nxt      = MEM_WAIT;
                if (state == RUN) begin
                    wait_cnt_nxt = WAIT_W'(1);
                end else if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end else begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
                if (e_pc_select_i) begin
                    // Taken branch squashes the dependent instr, so no load-use stall
                    branch_taken      = 1'b1;
                    ctrl.fd_flush     = 1'b1;
                    ctrl.de_flush     = 1'b1;
                    ctrl.pc_branch_en = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_stall = 1'b1;
                    ctrl.fd_stall = 1'b1;
                    ctrl.de_flush = 1'b1;
                end
            end
        end
    end

    // State, wait counter, sticky timeout and performance counters
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state          <= RUN;
            wait_cnt       <= '0;
            mem_timeout_o  <= 1'b0;
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (wait_cnt_nxt == WAIT_W'(MEM_TIMEOUT)) begin
                mem_timeout_o <= 1'b1;
            end
            if (ctrl.pc_stall) begin
                stall_cycles_o <= stall_cycles_o + CNT_W'(1);
            end
            if (branch_taken) begin
                flush_count_o <= flush_count_o + CNT_W'(1);
            end
        end
    end

    assign pc_stall_o     = ctrl.pc_stall;
    assign pc_branch_en_o = ctrl.pc_branch_en;
    assign fd_stall_o     = ctrl.fd_stall;
    assign fd_flush_o     = ctrl.fd_flush;
    assign de_stall_o     = ctrl.de_stall;
    assign de_flush_o     = ctrl.de_flush;
    assign em_stall_o     = ctrl.em_stall;
    assign mw_bubble_o    = ctrl.mw_bubble;
    assign fwd_a_o        = reset_i ? fwd_a_c : FWD_RF;
    assign fwd_b_o        = reset_i ? fwd_b_c : FWD_RF;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 3;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [4:0]    d_rs1_i, d_rs2_i, de_rs1_i, de_rs2_i, de_rd_i, em_rd_i, mw_rd_i;
    logic          d_uses_rs1_i, d_uses_rs2_i, de_mem_read_i, e_pc_select_i;
    logic          em_reg_write_i, dmem_req_i, dmem_ready_i, mw_reg_write_i;
    logic          pc_stall_o, pc_branch_en_o, fd_stall_o, fd_flush_o;
    logic          de_stall_o, de_flush_o, em_stall_o, mw_bubble_o, mem_timeout_o;
    logic [1:0]    fwd_a_o, fwd_b_o;
    logic [CW-1:0] stall_cycles_o, flush_count_o;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
        .d_uses_rs1_i(d_uses_rs1_i), .d_uses_rs2_i(d_uses_rs2_i),
        .de_rs1_i(de_rs1_i), .de_rs2_i(de_rs2_i), .de_rd_i(de_rd_i),
        .de_mem_read_i(de_mem_read_i), .e_pc_select_i(e_pc_select_i),
        .em_rd_i(em_rd_i), .em_reg_write_i(em_reg_write_i),
        .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .mw_rd_i(mw_rd_i), .mw_reg_write_i(mw_reg_write_i),
        .pc_stall_o(pc_stall_o), .pc_branch_en_o(pc_branch_en_o),
        .fd_stall_o(fd_stall_o), .fd_flush_o(fd_flush_o),
        .de_stall_o(de_stall_o), .de_flush_o(de_flush_o),
        .em_stall_o(em_stall_o), .mw_bubble_o(mw_bubble_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .mem_timeout_o(mem_timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: in a memory wait, how long, timeout seen, event counts
    bit m_waiting;
    int m_wait_len;
    bit m_timeout;
    int m_stalls;
    int m_flushes;
    bit e_freeze, e_branch, e_lu;

    function automatic int fwd_ref(int rs, bit em_w, int em_rd, bit mw_w, int mw_rd);
        if (rs != 0 && em_w && em_rd == rs) return 2;
        if (rs != 0 && mw_w && mw_rd == rs) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_wait_len = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Compare every output against the model for the currently driven inputs
    task automatic check_outputs();
        bit rst;
        logic [7:0] exp_ctrl;
        int fa, fb;
        rst      = !reset_i;
        e_freeze = !rst && (m_waiting ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i));
        e_branch = !rst && !e_freeze && e_pc_select_i;
        e_lu     = !rst && !e_freeze && !e_branch && de_mem_read_i && de_rd_i != 0 &&
                   ((d_uses_rs1_i && de_rd_i == d_rs1_i) || (d_uses_rs2_i && de_rd_i == d_rs2_i));
        // {pc_stall, branch_en, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_bubble}
        exp_ctrl = {e_freeze | e_lu, e_branch, e_freeze | e_lu, rst | e_branch,
                    e_freeze, rst | e_branch | e_lu, e_freeze, rst | e_freeze};
        fa = rst ? 0 : fwd_ref(de_rs1_i, em_reg_write_i, em_rd_i, mw_reg_write_i, mw_rd_i);
        fb = rst ? 0 : fwd_ref(de_rs2_i, em_reg_write_i, em_rd_i, mw_reg_write_i, mw_rd_i);
        check_eq("ctrl", 32'({pc_stall_o, pc_branch_en_o, fd_stall_o, fd_flush_o,
                              de_stall_o, de_flush_o, em_stall_o, mw_bubble_o}), 32'(exp_ctrl));
        check_eq("fwd_a", 32'(fwd_a_o), 32'(fa));
        check_eq("fwd_b", 32'(fwd_b_o), 32'(fb));
        check_eq("mem_timeout", 32'(mem_timeout_o), 32'(m_timeout));
        check_eq("stall_cycles", 32'(stall_cycles_o), 32'(m_stalls));
        check_eq("flush_count", 32'(flush_count_o), 32'(m_flushes));
    endtask

    task automatic model_edge();
        if (!reset_i) begin
            model_reset();
        end else begin
            if (e_freeze) begin
                m_wait_len = m_waiting ? m_wait_len + 1 : 1;
                if (m_wait_len > int'(TO)) m_wait_len = int'(TO);
                m_waiting = 1;
            end else begin
                m_waiting = 0;
                m_wait_len = 0;
            end
            if (m_waiting && m_wait_len == int'(TO)) m_timeout = 1;
            if (e_freeze || e_lu) m_stalls = (m_stalls + 1) % (1 << CW);
            if (e_branch) m_flushes = (m_flushes + 1) % (1 << CW);
        end
    endtask

    // Inputs are driven just after a negedge; check, cross posedge, return at negedge
    task automatic run_cycle();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset_i = 1; d_rs1_i = 0; d_rs2_i = 0; d_uses_rs1_i = 0; d_uses_rs2_i = 0;
        de_rs1_i = 0; de_rs2_i = 0; de_rd_i = 0; de_mem_read_i = 0; e_pc_select_i = 0;
        em_rd_i = 0; em_reg_write_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
        mw_rd_i = 0; mw_reg_write_i = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        @(negedge clk);

        // 1: reset held two cycles, then released
        reset_i = 0;
        run_cycle();
        run_cycle();
        check_eq("rst_flushes", 32'({fd_flush_o, de_flush_o, mw_bubble_o}), 32'(3'b111));
        check_eq("rst_stalls", 32'({pc_stall_o, fd_stall_o, de_stall_o, em_stall_o}), 32'(0));
        reset_i = 1;
        #1 check_eq("rel_flushes", 32'({fd_flush_o, de_flush_o, mw_bubble_o}), 32'(0));
        check_eq("rel_fwd", 32'({fwd_a_o, fwd_b_o}), 32'(0));
        run_cycle();

        // 2: load x5 in DE, decode reads x5
        de_mem_read_i = 1; de_rd_i = 5; d_uses_rs1_i = 1; d_rs1_i = 5;
        #1 check_eq("lu_stall", 32'({pc_stall_o, fd_stall_o, de_flush_o}), 32'(3'b111));
        run_cycle();
        de_mem_read_i = 0; de_rd_i = 0; de_rs1_i = 5; mw_rd_i = 5; mw_reg_write_i = 1;
        #1 check_eq("lu_release", 32'(pc_stall_o), 32'(0));
        check_eq("lu_fwd_mw", 32'(fwd_a_o), 32'(2'b01));
        check_eq("lu_stall_cnt", 32'(stall_cycles_o), 32'(1));
        run_cycle();

        // 3: branch together with a load-use: flush wins, no stall
        idle_inputs();
        de_mem_read_i = 1; de_rd_i = 6; d_uses_rs2_i = 1; d_rs2_i = 6; e_pc_select_i = 1;
        #1 check_eq("br_ctrl", 32'({pc_stall_o, fd_flush_o, de_flush_o, pc_branch_en_o}), 32'(4'b0111));
        run_cycle();
        check_eq("br_count", 32'(flush_count_o), 32'(1));

        // 4: dmem wait of four cycles then ready
        idle_inputs();
        dmem_req_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq("mw_freeze", 32'({pc_stall_o, de_stall_o, em_stall_o, mw_bubble_o}), 32'(4'hf));
            run_cycle();
        end
        dmem_ready_i = 1;
        #1 check_eq("mw_ready", 32'(pc_stall_o), 32'(0));
        check_eq("mw_stall_cnt", 32'(stall_cycles_o), 32'(5));
        run_cycle();
        dmem_req_i = 0;
        check_eq("mw_timeout_sticky", 32'(mem_timeout_o), 32'(1));
        run_cycle();

        // 5: forwarding priority and x0
        idle_inputs();
        em_rd_i = 7; mw_rd_i = 7; em_reg_write_i = 1; mw_reg_write_i = 1; de_rs2_i = 7;
        #1 check_eq("fwd_em_wins", 32'(fwd_b_o), 32'(2'b10));
        run_cycle();
        em_rd_i = 0; mw_rd_i = 0; de_rs1_i = 0;
        #1 check_eq("fwd_x0", 32'(fwd_a_o), 32'(0));
        run_cycle();

        // 6: timeout after the third wait cycle, cleared by reset; reset mid-freeze
        idle_inputs();
        reset_i = 0;
        run_cycle();
        reset_i = 1; dmem_req_i = 1;
        for (int i = 0; i < 3; i++) begin
            check_eq("to_before", 32'(mem_timeout_o), 32'(0));
            run_cycle();
        end
        check_eq("to_set", 32'(mem_timeout_o), 32'(1));
        dmem_ready_i = 1;
        run_cycle();
        dmem_ready_i = 0;
        run_cycle();
        reset_i = 0;
        run_cycle();
        reset_i = 1; dmem_req_i = 0;
        #1 check_eq("rst_abort", 32'({pc_stall_o, mem_timeout_o}), 32'(0));
        run_cycle();

        // Randomized traffic with small register range to provoke matches
        for (int n = 0; n < 3000; n++) begin
            reset_i        = ($urandom_range(0, 59) != 0);
            d_rs1_i        = 5'($urandom_range(0, 3));
            d_rs2_i        = 5'($urandom_range(0, 3));
            d_uses_rs1_i   = 1'($urandom_range(0, 1));
            d_uses_rs2_i   = 1'($urandom_range(0, 1));
            de_rs1_i       = 5'($urandom_range(0, 3));
            de_rs2_i       = 5'($urandom_range(0, 3));
            de_rd_i        = 5'($urandom_range(0, 3));
            de_mem_read_i  = 1'($urandom_range(0, 1));
            e_pc_select_i  = ($urandom_range(0, 5) == 0);
            em_rd_i        = 5'($urandom_range(0, 3));
            em_reg_write_i = 1'($urandom_range(0, 1));
            mw_rd_i        = 5'($urandom_range(0, 3));
            mw_reg_write_i = 1'($urandom_range(0, 1));
            dmem_req_i     = ($urandom_range(0, 2) == 0);
            dmem_ready_i   = ($urandom_range(0, 3) != 0) ^ (n[9] & ($urandom_range(0, 1) == 1));
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
